alu_seq: RTL and testbench
==========================

# alu_seq

Registered, parametrised successor to the team's 4-bit combinational ALU.
- Accepts an operation through a start/ready handshake and holds the result in an output register.
- Can take operand B from the low half of its own previous result (accumulator chaining).
- Adds a multi-cycle shift-add multiplier and a logical shift.
- Sits between the lab switch/key input logic and the HEX/LED display drivers; also usable as a datapath element under an FSM controller.

## Interface
Parameters:
- W, default 4, operand width; result width is 2W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted on a rising edge where start=1 and ready=1.
- func  in  3  operation select, sampled at accept.
- a  in  W  operand A, sampled at accept.
- b  in  W  operand B, sampled at accept.
- use_acc  in  1  at accept: 1 means B = result[W-1:0], 0 means B = b.
- ready  out  1  1 when a new request can be accepted.
- done  out  1  one-cycle pulse: result has just been updated.
- result  out  2W  registered result.
- zero  out  1  registered; 1 when result == 0.

## Operation
Functions (A, B zero-extended to 2W unless stated):
- 000: A+1; carry lands in bit W.
- 001: A+B; carry lands in bit W.
- 010: A−B, two's complement; W+1-bit difference sign-extended to 2W.
- 011: {A|B, A^B}.
- 100: {(2W−1)'b0, |{A,B}}.
- 101: {A,B}.
- 110: A*B, unsigned, multi-cycle shift-add, one multiplier bit per cycle.
- 111: A << B on 2W bits; B ≥ 2W gives 0.

Accept rules:
- All operands, func and the use_acc selection are latched at accept.
- Later changes to a/b/func/use_acc do not affect an operation in flight.

States: IDLE, MUL.
- IDLE
  - ready=1.
  - Accept of a non-110 func: result and zero update on the accept edge, done=1 for the following cycle, stay in IDLE.
  - Accept of 110: clear the partial product, load a W-step counter, go to MUL.
- MUL
  - ready=0.
  - Each edge: if the current multiplier LSB is 1, add the shifted multiplicand; shift; decrement the counter.
  - On the W-th edge after accept: write the product to result/zero, done=1 for the following cycle, return to IDLE.
- result holds its value between updates; it is not cleared at accept.
- start while ready=0: ignored, not queued.
- use_acc=1 on the very first operation after reset uses B=0.

## Timing
- Reset values: result=0, zero=1, done=0, ready=1, state IDLE, counter 0.
- Reset asserted mid-MUL aborts the operation immediately: the partial product is discarded, outputs take their reset values, and no done pulse is emitted.
- Non-multiply latency: accept at edge E0; result valid and done=1 in cycle E0→E1.
- Back-to-back non-multiply accepts every cycle are legal; done stays high continuously, one pulse per operation.
- Multiply latency:
  - Accept at E0; the result updates at edge EW.
  - ready=0 for cycles E0→EW.
  - In cycle EW→EW+1: done=1 and ready=1 together. A start there is accepted at EW+1.
- done is never high for more than one cycle per accepted operation.

## Configuration
- ALU_SEQ_MUL_EN defined:
  - func 110 is the multi-cycle multiplier as above; MUL state and counter are present.
- ALU_SEQ_MUL_EN undefined:
  - No MUL state, counter or multiplier logic.
  - func 110 completes in one cycle like the other ops, with result=0 and zero=1.
  - ready is tied to 1 outside reset.

## Test plan
W=4, ALU_SEQ_MUL_EN defined unless noted.
- Reset: hold resetn=0 → result=8'h00, zero=1, done=0, ready=1. Release, then idle 3 cycles → outputs unchanged.
- Arithmetic:
  - func 001, a=F, b=1 → next cycle result=8'h10, done=1 for exactly one cycle.
  - func 010, a=2, b=5 → 8'hFD.
  - func 011, a=A, b=5 → 8'hFF.
- Multiply: func 110, a=F, b=D.
  - ready=0 for 4 cycles.
  - A start with func 001 during busy is ignored.
  - Then result=8'hC3 and done=1 together with ready=1.
- Chaining:
  - func 101, a=3, b=2 → 8'h32.
  - Next: func 001, use_acc=1, a=1, b=F → 8'h03.
- Shift and OR: func 111, a=1, b=7 → 8'h80; b=8 → 8'h00, zero=1; func 100, a=0, b=0 → 8'h00.
- Reset and configuration:
  - Assert resetn=0 two cycles into a multiply → result=0, ready=1, no done pulse.
  - Rebuild without ALU_SEQ_MUL_EN: func 110, a=F, b=D → result=0 after one cycle, ready never low.

Source files
------------

// File: rtl/alu_seq_if.sv
// Handshake/result bundle for alu_seq: the requester drives the master side,
// the ALU implements the slave side.
interface alu_seq_if #(
  parameter int W = 4
);
  logic           start;
  logic [2:0]     func;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           use_acc;
  logic           ready;
  logic           done;
  logic [2*W-1:0] result;
  logic           zero;

  modport master (
    output start, func, a, b, use_acc,
    input  ready, done, result, zero
  );

  modport slave (
    input  start, func, a, b, use_acc,
    output ready, done, result, zero
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with start/ready handshake and accumulator chaining.
// Define ALU_SEQ_MUL_EN to build func 110 as a W-cycle shift-add multiplier.
module alu_seq #(
  parameter int W = 4
) (
  input  logic     clk,
  input  logic     resetn,
  alu_seq_if.slave bus
);
  localparam int RW = 2 * W;

  logic [RW-1:0] r_result;
  logic          r_zero;
  logic          r_done;
  logic          w_ready;
  logic          w_accept;
  logic          w_is_mul;
  logic          w_mul_last;
  logic [RW-1:0] w_mul_result;
  logic [W-1:0]  w_b;
  logic [RW-1:0] w_a_ext;
  logic [RW-1:0] w_b_ext;
  logic [W:0]    w_diff;
  logic [RW-1:0] w_alu;

  // Chaining takes B from the low half of the result currently held.
  assign w_b      = bus.use_acc ? r_result[W-1:0] : bus.b;
  assign w_a_ext  = {{W{1'b0}}, bus.a};
  assign w_b_ext  = {{W{1'b0}}, w_b};
  assign w_diff   = {1'b0, bus.a} - {1'b0, w_b};
  assign w_accept = bus.start && w_ready;

  always_comb begin
    w_alu = '0;
    case (bus.func)
      3'b000:  w_alu = w_a_ext + RW'(1);
      3'b001:  w_alu = w_a_ext + w_b_ext;
      3'b010:  w_alu = {{(W-1){w_diff[W]}}, w_diff};
      3'b011:  w_alu = {bus.a | w_b, bus.a ^ w_b};
      3'b100:  w_alu = {{(RW-1){1'b0}}, |{bus.a, w_b}};
      3'b101:  w_alu = {bus.a, w_b};
      3'b111:  w_alu = (32'(w_b) >= 32'(RW)) ? '0 : (w_a_ext << w_b);
      default: w_alu = '0;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CW = $clog2(W + 1);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_mcand;
  logic [RW-1:0] r_acc;
  logic [W-1:0]  r_mplier;

  assign w_is_mul     = (bus.func == 3'b110);
  assign w_mul_last   = (r_state == S_MUL) && (r_cnt == CW'(1));
  assign w_mul_result = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_next = S_MUL;
      S_MUL:   if (w_mul_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_ready = (r_state == S_IDLE);
  end

  // One multiplier bit per edge; the final sum goes straight to the result register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
    end else if (w_accept && w_is_mul) begin
      r_cnt    <= CW'(W);
      r_mcand  <= w_a_ext;
      r_acc    <= '0;
      r_mplier <= w_b;
    end else if (r_state == S_MUL) begin
      r_cnt    <= r_cnt - CW'(1);
      r_mcand  <= r_mcand << 1;
      r_acc    <= w_mul_result;
      r_mplier <= r_mplier >> 1;
    end
  end
`else
  assign w_ready      = 1'b1;
  assign w_is_mul     = 1'b0;
  assign w_mul_last   = 1'b0;
  assign w_mul_result = '0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_result <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      r_result <= w_alu;
      r_zero   <= (w_alu == '0);
      r_done   <= 1'b1;
    end else if (w_mul_last) begin
      r_result <= w_mul_result;
      r_zero   <= (w_mul_result == '0);
      r_done   <= 1'b1;
    end else begin
      r_done   <= 1'b0;
    end
  end

  assign bus.ready  = w_ready;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.zero   = r_zero;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver pushes expected results with their
// due cycle, a negedge monitor pops on every done pulse and compares.
`timescale 1ns/1ps
module tb_alu_seq;
  localparam int W  = 4;
  localparam int RW = 2 * W;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  localparam int MUL_FD = MUL_EN ? 'hC3 : 0;

  typedef struct {
    int res;
    int cyc;
  } exp_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;

  alu_seq_if #(.W(W)) bus ();
  alu_seq #(.W(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   busy     = 0;
  int   m_res    = 0;
  int   hold_res = 0;
  bit   mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference behaviour straight from the operation table.
  function automatic int ref_op(int f, int a, int b);
    int r;
    case (f)
      0: r = a + 1;
      1: r = a + b;
      2: r = a - b;
      3: r = ((a | b) << W) | (a ^ b);
      4: r = (a != 0 || b != 0) ? 1 : 0;
      5: r = (a << W) | b;
      6: r = MUL_EN ? a * b : 0;
      default: r = (b >= RW) ? 0 : (a << b);
    endcase
    return r & ((1 << RW) - 1);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("result", int'(bus.result), e.res);
          check("zero", int'(bus.zero), int'(e.res == 0));
          check("done_cycle", cyc, e.cyc);
          hold_res = e.res;
          $display("op done cyc=%0d result=0x%02h", cyc, bus.result);
        end
      end else begin
        if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
          check("missing_done", 0, 1);
          void'(sb_q.pop_front());
        end
        check("hold", int'(bus.result), hold_res);
      end
    end
  end

  task automatic step(input bit st, input int f, input int a, input int b, input bit ua,
                      input bit forced, input int fexp, output bit issued);
    bit   rdy;
    bit   is_mul;
    int   bb;
    exp_t e;
    @(negedge clk);
    rdy = (busy == 0);
    check("ready", int'(bus.ready), int'(rdy));
    if (!rdy) busy--;
    issued      = 1'b0;
    bus.start   = st;
    bus.func    = f[2:0];
    bus.a       = a[W-1:0];
    bus.b       = b[W-1:0];
    bus.use_acc = ua;
    if (st && rdy) begin
      bb     = ua ? (m_res & ((1 << W) - 1)) : b;
      e.res  = forced ? fexp : ref_op(f, a, bb);
      is_mul = MUL_EN && (f == 6);
      e.cyc  = cyc + 1 + (is_mul ? W : 0);
      sb_q.push_back(e);
      m_res  = e.res;
      if (is_mul) busy = W;
      issued = 1'b1;
    end
  endtask

  task automatic op(input int f, input int a, input int b, input bit ua,
                    input bit forced, input int fexp);
    bit iss;
    iss = 1'b0;
    while (!iss) step(1'b1, f, a, b, ua, forced, fexp, iss);
  endtask

  task automatic idle(input int n);
    bit iss;
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 1'b0, 1'b0, 0, iss);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int f;
    int a;
    int b;
    bit ua;
    bit iss;
    bus.start   = 1'b0;
    bus.func    = '0;
    bus.a       = '0;
    bus.b       = '0;
    bus.use_acc = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_result", int'(bus.result), 0);
    check("rst_zero", int'(bus.zero), 1);
    check("rst_done", int'(bus.done), 0);
    check("rst_ready", int'(bus.ready), 1);
    resetn = 1'b1;
    mon_en = 1'b1;
    idle(3);
    check("idle_result", int'(bus.result), 0);
    check("idle_zero", int'(bus.zero), 1);
    check("idle_done", int'(bus.done), 0);

    op(1, 'hF, 'h1, 1'b0, 1'b1, 'h10);
    op(2, 'h2, 'h5, 1'b0, 1'b1, 'hFD);
    op(3, 'hA, 'h5, 1'b0, 1'b1, 'hFF);
    op(6, 'hF, 'hD, 1'b0, 1'b1, MUL_FD);
    step(1'b1, 1, 3, 3, 1'b0, 1'b0, 0, iss);
    op(5, 'h3, 'h2, 1'b0, 1'b1, 'h32);
    op(1, 'h1, 'hF, 1'b1, 1'b1, 'h03);
    op(7, 'h1, 'h7, 1'b0, 1'b1, 'h80);
    op(7, 'h1, 'h8, 1'b0, 1'b1, 'h00);
    op(4, 'h0, 'h0, 1'b0, 1'b1, 'h00);

    for (int i = 0; i < 400; i++) begin
      f  = $urandom_range(0, 7);
      a  = $urandom_range(0, 15);
      b  = $urandom_range(0, 15);
      ua = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) idle(1);
      op(f, a, b, ua, 1'b0, 0);
    end
    idle(W + 3);
    check("drain", sb_q.size(), 0);

    // Abort a multiply two cycles in: no done pulse may follow.
    op(6, 'hF, 'hD, 1'b0, 1'b0, 0);
    idle(2);
    resetn = 1'b0;
    mon_en = 1'b0;
    #1;
    check("abort_result", int'(bus.result), 0);
    check("abort_zero", int'(bus.zero), 1);
    check("abort_done", int'(bus.done), 0);
    check("abort_ready", int'(bus.ready), 1);
    sb_q.delete();
    busy     = 0;
    m_res    = 0;
    hold_res = 0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    mon_en = 1'b1;
    idle(W + 4);
    op(0, 'h7, 'h0, 1'b0, 1'b1, 'h08);
    idle(2);
    check("final_drain", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
